vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator and pixel output stage.
- Replaces the fixed 640x480 display block.
- Generates horizontal and vertical counters, a pixel request with coordinates, and sync, blanking and frame/line markers.
- Handles a pixel source with configurable read latency and aligns sync to returned pixel data; sits between the game/frame logic and the VGA connector.

---
 rtl/vga_timing_gen.sv | 214 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Parametrised VGA raster timing generator with a latency-matched pixel output stage.
// Optional feature macro: VGA_TEST_PATTERN_EN (internal 8-bar colour pattern on pattern_en).

module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 4,
  parameter int CNT_W     = 10,
  parameter int DATA_LAT  = 1
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  input  logic                   pattern_en,
  output logic                   pix_req,
  output logic [CNT_W-1:0]       pix_x,
  output logic [CNT_W-1:0]       pix_y,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     green_out,
  output logic [COLOR_W-1:0]     blue_out,
  output logic                   hSync,
  output logic                   vSync,
  output logic                   active,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CNT_W + 1;
  localparam int RGB_W   = 3 * COLOR_W;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Window bounds are one bit wider than the counters so a bound equal to
  // 2^CNT_W (zero back porch at maximum total) still compares correctly.
  localparam logic [CNT_W:0] H_ACT_C = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_C = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG  = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END  = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG  = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END  = CW1'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic       req;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } flags_t;

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [CNT_W:0]   h_x, v_x;

  flags_t st0;
  flags_t dly;

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             act_q, act_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_x   = {1'b0, h_q};
  assign v_x   = {1'b0, v_q};
  assign pix_x = h_q;
  assign pix_y = v_q;

  // ---------------------------------------------------------------------------
  // Stage-0 decode
  // ---------------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  function automatic logic [2:0] bar_of(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] idx;
    idx = x / CNT_W'(BAR_W);
    return (idx > CNT_W'(7)) ? 3'd7 : idx[2:0];
  endfunction

  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] b);
    return {{COLOR_W{b[2]}}, {COLOR_W{b[1]}}, {COLOR_W{b[0]}}};
  endfunction
`endif

  always_comb begin
    st0     = '0;
    st0.req = (h_x < H_ACT_C) && (v_x < V_ACT_C);
    st0.hs  = (h_x >= HS_BEG) && (h_x < HS_END);
    st0.vs  = (v_x >= VS_BEG) && (v_x < VS_END);
    st0.ls  = (h_q == '0);
    st0.fs  = (h_q == '0) && (v_q == '0);
`ifdef VGA_TEST_PATTERN_EN
    st0.bar = bar_of(h_q);
`endif
  end

  assign pix_req = st0.req;

  // ---------------------------------------------------------------------------
  // Alignment delay line: flags travel with the pixel source's read latency
  // ---------------------------------------------------------------------------
  if (DATA_LAT == 0) begin : g_no_pipe
    assign dly = st0;
  end else begin : g_pipe
    flags_t pipe_q [DATA_LAT];

    // NOTE: the delay line is reset like any other flop so stale sync and
    // marker flags from an aborted frame never reach the outputs.
    always_ff @(posedge clk25) begin
      if (!rst_n) begin
        for (int i = 0; i < DATA_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= st0;
        for (int i = 1; i < DATA_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[DATA_LAT-1];
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
`ifndef VGA_TEST_PATTERN_EN
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
`endif

  always_comb begin
    rgb_d = '0;
    if (dly.req) begin
`ifdef VGA_TEST_PATTERN_EN
      rgb_d = pattern_en ? bar_rgb(dly.bar) : rgb_in;
`else
      rgb_d = rgb_in;
`endif
    end
    act_d = dly.req;
    hs_d  = dly.hs ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = dly.vs ? VSYNC_POL : ~VSYNC_POL;
    ls_d  = dly.ls;
    fs_d  = dly.fs;
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      rgb_q <= '0;
      act_q <= 1'b0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign red_out     = rgb_q[RGB_W-1 -: COLOR_W];
  assign green_out   = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue_out    = rgb_q[COLOR_W-1:0];
  assign active      = act_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Self-checking bench for vga_timing_gen: four configurations run side by side
// against an arithmetic raster model, plus vector tables and corner sequences.

module tb_vga_timing_gen;

  localparam int N = 4;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hpol, vpol;
    int lat;
    bit pat;
    bit echo;
  } cfg_t;

  typedef struct {
    string       name;
    int          h;
    int          v;
    bit          act;
    logic [11:0] rgb;
    bit          hs, vs, ls, fs;
  } vec_t;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] rgb  [N];
  logic        pen  [N];
  logic        req_o[N];
  logic [9:0]  x_o  [N];
  logic [9:0]  y_o  [N];
  logic [3:0]  r_o  [N];
  logic [3:0]  g_o  [N];
  logic [3:0]  b_o  [N];
  logic        hs_o [N];
  logic        vs_o [N];
  logic        act_o[N];
  logic        ls_o [N];
  logic        fs_o [N];

  cfg_t   cfg [N];
  longint e_cnt    = 0;
  bit     run_chk  = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;

  always #20 clk25 = ~clk25;

  // Edges since the last reset edge; the model is a pure function of this.
  always @(posedge clk25) e_cnt <= rst_n ? e_cnt + 1 : 0;

  vga_timing_gen #(.DATA_LAT(1)) u_d1 (
    .clk25(clk25), .rst_n(rst_n), .rgb_in(rgb[0]), .pattern_en(pen[0]),
    .pix_req(req_o[0]), .pix_x(x_o[0]), .pix_y(y_o[0]),
    .red_out(r_o[0]), .green_out(g_o[0]), .blue_out(b_o[0]),
    .hSync(hs_o[0]), .vSync(vs_o[0]), .active(act_o[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]));

  vga_timing_gen #(.DATA_LAT(0)) u_d0 (
    .clk25(clk25), .rst_n(rst_n), .rgb_in(rgb[1]), .pattern_en(pen[1]),
    .pix_req(req_o[1]), .pix_x(x_o[1]), .pix_y(y_o[1]),
    .red_out(r_o[1]), .green_out(g_o[1]), .blue_out(b_o[1]),
    .hSync(hs_o[1]), .vSync(vs_o[1]), .active(act_o[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]));

  vga_timing_gen #(.DATA_LAT(3)) u_d3 (
    .clk25(clk25), .rst_n(rst_n), .rgb_in(rgb[2]), .pattern_en(pen[2]),
    .pix_req(req_o[2]), .pix_x(x_o[2]), .pix_y(y_o[2]),
    .red_out(r_o[2]), .green_out(g_o[2]), .blue_out(b_o[2]),
    .hSync(hs_o[2]), .vSync(vs_o[2]), .active(act_o[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .DATA_LAT(2)
  ) u_sm (
    .clk25(clk25), .rst_n(rst_n), .rgb_in(rgb[3]), .pattern_en(pen[3]),
    .pix_req(req_o[3]), .pix_x(x_o[3]), .pix_y(y_o[3]),
    .red_out(r_o[3]), .green_out(g_o[3]), .blue_out(b_o[3]),
    .hSync(hs_o[3]), .vSync(vs_o[3]), .active(act_o[3]),
    .line_start(ls_o[3]), .frame_start(fs_o[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: raster position is plain arithmetic on the edge count
  // ---------------------------------------------------------------------------
  function automatic cfg_t mk_cfg(int ha, int hf, int hs, int hb, int va, int vf, int vs,
                                  int vb, bit hpol, bit vpol, int lat, bit pat, bit echo);
    cfg_t c;
    c.ha = ha; c.hf = hf; c.hs = hs; c.hb = hb;
    c.va = va; c.vf = vf; c.vs = vs; c.vb = vb;
    c.hpol = hpol; c.vpol = vpol; c.lat = lat; c.pat = pat; c.echo = echo;
    return c;
  endfunction

  function automatic int h_tot(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int v_tot(cfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic logic [11:0] echo_rgb(int h, int v);
    logic [9:0] x, y;
    x = h[9:0];
    y = v[9:0];
    return {x[3:0], y[3:0], 4'hA};
  endfunction

  function automatic logic [11:0] bar_rgb(cfg_t c, int h);
    int i;
    i = h / ((c.ha >= 8) ? c.ha / 8 : 1);
    if (i > 7) i = 7;
    return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
  endfunction

  // {active, rgb[11:0], hSync, vSync, line_start, frame_start} after edge e
  function automatic logic [16:0] model_out(cfg_t c, longint e, logic [11:0] rgb_now);
    longint      p;
    int          h, v;
    bit          vis;
    logic [16:0] r;
    p = e - 1 - c.lat;
    r = {1'b0, 12'h000, ~c.hpol, ~c.vpol, 2'b00};
    if (p >= 0) begin
      h     = int'(p % h_tot(c));
      v     = int'((p / h_tot(c)) % v_tot(c));
      vis   = (h < c.ha) && (v < c.va);
      r[16] = vis;
      r[15:4] = !vis ? 12'h000 : (c.pat ? bar_rgb(c, h) : rgb_now);
      r[3]  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : ~c.hpol;
      r[2]  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : ~c.vpol;
      r[1]  = (h == 0);
      r[0]  = (h == 0) && (v == 0);
    end
    return r;
  endfunction

  // {pix_req, pix_x, pix_y} after edge e
  function automatic logic [20:0] pos_exp(cfg_t c, longint e);
    int h, v;
    h = int'(e % h_tot(c));
    v = int'((e / h_tot(c)) % v_tot(c));
    return {(h < c.ha) && (v < c.va), 10'(h), 10'(v)};
  endfunction

  // Source data sampled at edge e+1, which belongs to raster position e-lat.
  function automatic logic [11:0] next_rgb(cfg_t c, longint e);
    longint q;
    int     h, v;
    q = e - c.lat;
    if (c.echo && q >= 0) begin
      h = int'(q % h_tot(c));
      v = int'((q / h_tot(c)) % v_tot(c));
      if (h < c.ha && v < c.va) return echo_rgb(h, v);
    end
    return 12'($urandom);
  endfunction

  initial begin : model_proc
    forever begin
      @(negedge clk25);
      if (run_chk) begin
        for (int k = 0; k < N; k++) begin
          check($sformatf("out[%0d]", k),
                64'({act_o[k], r_o[k], g_o[k], b_o[k], hs_o[k], vs_o[k], ls_o[k], fs_o[k]}),
                64'(model_out(cfg[k], e_cnt, rgb[k])));
          check($sformatf("pos[%0d]", k), 64'({req_o[k], x_o[k], y_o[k]}),
                64'(pos_exp(cfg[k], e_cnt)));
          rgb[k] = next_rgb(cfg[k], e_cnt);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  task automatic wait_e(input longint t);
    while (e_cnt < t) @(negedge clk25);
  endtask

  function automatic bit pulse_of(int k, int sel);
    return (sel == 0) ? ls_o[k] : fs_o[k];
  endfunction

  // Edge count of the next line_start (sel 0) or frame_start (sel 1) pulse, -1 on timeout.
  task automatic next_pulse(input int k, input int sel, input int bound, output longint t);
    int n;
    n = 0;
    t = -1;
    @(negedge clk25);
    while (!pulse_of(k, sel) && n < bound) begin
      @(negedge clk25);
      n++;
    end
    if (pulse_of(k, sel)) t = e_cnt;
  endtask

  task automatic period_check(input string name, input int k, input int sel,
                              input int bound, input int exp);
    longint t1, t2, d;
    next_pulse(k, sel, bound, t1);
    next_pulse(k, sel, bound, t2);
    d = (t1 < 0 || t2 < 0) ? -1 : t2 - t1;
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic run_table();
    vec_t tbl[13];
    tbl[0]  = '{"origin",   0,   0, 1'b1, 12'h00A, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{"x5y0",     5,   0, 1'b1, 12'h50A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{"x639y0",   639, 0, 1'b1, 12'hF0A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{"x640y0",   640, 0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{"fp_last",  655, 0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{"hs_first", 656, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{"hs_last",  751, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{"bp_first", 752, 0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{"h799",     799, 0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{"line1",    0,   1, 1'b1, 12'h01A, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{"x5y7",     5,   7, 1'b1, 12'h57A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{"x100y8",   100, 8, 1'b1, 12'h48A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{"x639y8",   639, 8, 1'b1, 12'hF8A, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      wait_e(longint'(tbl[i].v) * 800 + tbl[i].h + 2);
      check({"tbl_", tbl[i].name},
            64'({act_o[0], r_o[0], g_o[0], b_o[0], hs_o[0], vs_o[0], ls_o[0], fs_o[0]}),
            64'({tbl[i].act, tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs}));
    end
  endtask

  task automatic echo_lat_checks();
    wait_e(7 * 800 + 5 + 1);
    check("lat0_x5y7", 64'({act_o[1], r_o[1], g_o[1], b_o[1]}), 64'({1'b1, 12'h57A}));
    wait_e(7 * 800 + 5 + 4);
`ifdef VGA_TEST_PATTERN_EN
    check("lat3_x5y7", 64'({act_o[2], r_o[2], g_o[2], b_o[2]}), 64'({1'b1, 12'h000}));
`else
    check("lat3_x5y7", 64'({act_o[2], r_o[2], g_o[2], b_o[2]}), 64'({1'b1, 12'h57A}));
`endif
    wait_e(7 * 800 + 640 + 4);
    check("lat3_x640y7", 64'({act_o[2], r_o[2], g_o[2], b_o[2]}), 64'({1'b0, 12'h000}));
  endtask

  task automatic pattern_checks();
`ifdef VGA_TEST_PATTERN_EN
    int          xs [6];
    logic [11:0] cs [6];
    xs = '{0, 79, 80, 159, 560, 639};
    cs = '{12'h000, 12'h000, 12'h00F, 12'h00F, 12'hFFF, 12'hFFF};
    for (int i = 0; i < 6; i++) begin
      wait_e(2 * 800 + xs[i] + 4);
      check($sformatf("bar_x%0d", xs[i]), 64'({r_o[2], g_o[2], b_o[2]}), 64'(cs[i]));
    end
`endif
  endtask

  task automatic hsync_width_d1();
    bit prev, fell;
    int n;
    prev = hs_o[0];
    fell = 1'b0;
    for (int i = 0; i < 2000 && !fell; i++) begin
      @(negedge clk25);
      fell = prev && !hs_o[0];
      prev = hs_o[0];
    end
    check("hs_fall_seen", 64'(fell), 64'(1));
    if (fell) begin
      check("hs_fall_h", 64'((e_cnt - 2) % 800), 64'(656));
      n = 0;
      while (!hs_o[0] && n < 200) begin
        n++;
        @(negedge clk25);
      end
      check("hs_low_width", 64'(n), 64'(96));
    end
  endtask

  task automatic small_periods();
    longint t;
    int     cnt;
    period_check("sm_line_period", 3, 0, 40, 14);
    period_check("sm_frame_period", 3, 1, 300, 98);
    next_pulse(3, 0, 40, t);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cnt += int'(hs_o[3]);
      @(negedge clk25);
    end
    check("sm_hs_high", 64'(cnt), 64'(2));
    next_pulse(3, 1, 300, t);
    cnt = 0;
    for (int i = 0; i < 98; i++) begin
      cnt += int'(!vs_o[3]);
      @(negedge clk25);
    end
    check("sm_vs_low", 64'(cnt), 64'(14));
  endtask

  task automatic mid_reset();
    int hr, n;
    int seen [N];
    hr = $urandom_range(300, 760);
    n  = 0;
    while (int'(e_cnt % 800) != hr && n < 1000) begin
      @(negedge clk25);
      n++;
    end
    check("mrst_reach_h", 64'(e_cnt % 800), 64'(hr));
    rst_n = 1'b0;
    @(negedge clk25);
    check("mrst_pix", 64'({req_o[0], x_o[0], y_o[0]}), 64'({1'b1, 20'd0}));
    check("mrst_out", 64'({act_o[0], r_o[0], g_o[0], b_o[0], hs_o[0], vs_o[0], ls_o[0], fs_o[0]}),
          64'({1'b0, 12'h000, 1'b1, 1'b1, 2'b00}));
    check("mrst_sm_hs", 64'(hs_o[3]), 64'(0));
    repeat ($urandom_range(0, 2)) @(negedge clk25);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) seen[k] = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk25);
      #1;
      for (int k = 0; k < N; k++) if (fs_o[k] && seen[k] == 0) seen[k] = c;
    end
    for (int k = 0; k < N; k++)
      check($sformatf("mrst_fs_lat[%0d]", k), 64'(seen[k]), 64'(cfg[k].lat + 1));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main_proc
    bit pat3;
`ifdef VGA_TEST_PATTERN_EN
    pat3 = 1'b1;
`else
    pat3 = 1'b0;
`endif
    cfg[0] = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    cfg[1] = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    cfg[2] = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 3, pat3, 1'b1);
    cfg[3] = mk_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    pen[0] = 1'b0;
    pen[1] = 1'b0;
    pen[2] = 1'b1;
    pen[3] = 1'b0;
    for (int k = 0; k < N; k++) rgb[k] = '0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk25);
    #1 run_chk = 1'b1;
    @(negedge clk25);
    check("rst_d1_pix", 64'({req_o[0], x_o[0], y_o[0]}), 64'({1'b1, 20'd0}));
    check("rst_d1_out", 64'({act_o[0], r_o[0], g_o[0], b_o[0], hs_o[0], vs_o[0], ls_o[0], fs_o[0]}),
          64'({1'b0, 12'h000, 1'b1, 1'b1, 2'b00}));
    check("rst_sm_sync", 64'({hs_o[3], vs_o[3]}), 64'(2'b01));
    rst_n = 1'b1;

    fork
      run_table();
      echo_lat_checks();
      pattern_checks();
      hsync_width_d1();
      small_periods();
      period_check("d1_line_period", 0, 0, 2000, 800);
    join

    mid_reset();
    repeat (1700) @(negedge clk25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
